csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode trap entry / MRET sequencer in front of a CSR file.
// In IDLE the pipeline's CSR accesses pass straight through to the CSR file.
// When a trap is accepted, the pipeline is stalled while mepc, mcause, mtval
// and mstatus are written one per cycle, and then fetch is redirected to mtvec.
// MRET updates mstatus and then redirects to the latched mepc.
// Optional feature: define CSR_TRAP_VECTORED_EN to enable vectored trap targets.
// The default build (macro undefined) always redirects to mtvec & ~3.
//
// Handshake: exc_req / mret_req are level requests held by the requester until
// the matching one-cycle ack. An ack can only fire in IDLE. Requests that arrive
// outside IDLE are ignored and are accepted once the FSM is back in IDLE.
// Exceptions win over MRET, and MRET wins over a pipeline CSR write.
module csr_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic        pl_csr_w,
    input  logic [11:0] pl_waddr,
    input  logic [31:0] pl_wdata,
    input  logic [1:0]  pl_mode,
    input  logic [11:0] pl_raddr,
    input  logic [31:0] mstatus,
    input  logic [31:0] mepc,
    input  logic [31:0] csr_rdata,
    output logic        exc_ack,
    output logic        mret_ack,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc_mode,
    output logic [11:0] csr_raddr,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [2:0]  dbg_state
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0]  MODE_WRITE   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_W_MRET    = 3'd5,
        ST_REDIRECT  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_mstatus;
    logic [31:0] r_target;

    logic [31:0] w_trap_mstatus;
    logic [31:0] w_mret_mstatus;
    logic [31:0] w_trap_target;

    assign dbg_state = r_state;

    // mstatus images for trap entry (MPIE<=MIE, MIE<=0, MPP<=M) and MRET (MIE<=MPIE, MPIE<=1, MPP<=M)
    always_comb begin
        w_trap_mstatus        = r_mstatus;
        w_trap_mstatus[7]     = r_mstatus[3];
        w_trap_mstatus[3]     = 1'b0;
        w_trap_mstatus[12:11] = 2'b11;
        w_mret_mstatus        = r_mstatus;
        w_mret_mstatus[3]     = r_mstatus[7];
        w_mret_mstatus[7]     = 1'b1;
        w_mret_mstatus[12:11] = 2'b11;
    end

    // Trap target from the mtvec value read back during W_MSTATUS
    always_comb begin
        w_trap_target = csr_rdata & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
        // Vectored mode only applies to interrupts (cause MSB set); offset wraps at 32 bits
        if ((csr_rdata[1:0] == 2'b01) && r_cause[31]) begin
            w_trap_target = (csr_rdata & 32'hFFFF_FFFC) + {r_cause[29:0], 2'b00};
        end
`endif
    end

    // State register; reset aborts any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: fixed write sequence after an accept, always ending in one REDIRECT cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (exc_req) begin
                    w_next_state = ST_W_MEPC;
                end else if (mret_req) begin
                    w_next_state = ST_W_MRET;
                end
            end
            ST_W_MEPC:    w_next_state = ST_W_MCAUSE;
            ST_W_MCAUSE:  w_next_state = ST_W_MTVAL;
            ST_W_MTVAL:   w_next_state = ST_W_MSTATUS;
            ST_W_MSTATUS: w_next_state = ST_REDIRECT;
            ST_W_MRET:    w_next_state = ST_REDIRECT;
            ST_REDIRECT:  w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Latch trap/MRET context on accept and the final redirect target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause   <= 32'h0;
            r_epc     <= 32'h0;
            r_tval    <= 32'h0;
            r_mstatus <= 32'h0;
            r_target  <= 32'h0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (exc_req) begin
                    r_cause   <= exc_cause;
                    r_epc     <= exc_pc;
                    r_tval    <= exc_tval;
                    r_mstatus <= mstatus;
                end else if (mret_req) begin
                    r_mstatus <= mstatus;
                    r_target  <= mepc;
                end
            end else if (r_state == ST_W_MSTATUS) begin
                r_target <= w_trap_target;
            end
        end
    end

    // Outputs: IDLE pass-through or accept, one sequenced write per W_* state, all zero in reset
    always_comb begin
        exc_ack      = 1'b0;
        mret_ack     = 1'b0;
        csr_w        = 1'b0;
        csr_waddr    = 12'h0;
        csr_wdata    = 32'h0;
        csr_wsc_mode = 2'b00;
        csr_raddr    = ADDR_MTVEC;
        stall        = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        case (r_state)
            ST_IDLE: begin
                csr_raddr    = pl_raddr;
                csr_waddr    = pl_waddr;
                csr_wdata    = pl_wdata;
                csr_wsc_mode = pl_mode;
                stall        = 1'b0;
                if (exc_req) begin
                    exc_ack = 1'b1;
                    stall   = 1'b1;
                end else if (mret_req) begin
                    mret_ack = 1'b1;
                    stall    = 1'b1;
                end else begin
                    csr_w = pl_csr_w;
                end
            end
            ST_W_MEPC: begin
                csr_w        = 1'b1;
                csr_waddr    = ADDR_MEPC;
                csr_wdata    = r_epc & 32'hFFFF_FFFC;
                csr_wsc_mode = MODE_WRITE;
            end
            ST_W_MCAUSE: begin
                csr_w        = 1'b1;
                csr_waddr    = ADDR_MCAUSE;
                csr_wdata    = r_cause;
                csr_wsc_mode = MODE_WRITE;
            end
            ST_W_MTVAL: begin
                csr_w        = 1'b1;
                csr_waddr    = ADDR_MTVAL;
                csr_wdata    = r_tval;
                csr_wsc_mode = MODE_WRITE;
            end
            ST_W_MSTATUS: begin
                csr_w        = 1'b1;
                csr_waddr    = ADDR_MSTATUS;
                csr_wdata    = w_trap_mstatus;
                csr_wsc_mode = MODE_WRITE;
            end
            ST_W_MRET: begin
                csr_w        = 1'b1;
                csr_waddr    = ADDR_MSTATUS;
                csr_wdata    = w_mret_mstatus;
                csr_wsc_mode = MODE_WRITE;
            end
            ST_REDIRECT: begin
                redirect    = 1'b1;
                redirect_pc = r_target;
            end
            default: begin
                stall = 1'b1;
            end
        endcase
        if (rst) begin
            exc_ack      = 1'b0;
            mret_ack     = 1'b0;
            csr_w        = 1'b0;
            csr_waddr    = 12'h0;
            csr_wdata    = 32'h0;
            csr_wsc_mode = 2'b00;
            csr_raddr    = 12'h0;
            stall        = 1'b0;
            redirect     = 1'b0;
            redirect_pc  = 32'h0;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl. Writes and redirects are checked by a
// cycle-tagged scoreboard; handshake/stall behaviour is checked inline per task.
// Vectored expectations follow CSR_TRAP_VECTORED_EN.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_req;
    logic        pl_csr_w;
    logic [11:0] pl_waddr;
    logic [31:0] pl_wdata;
    logic [1:0]  pl_mode;
    logic [11:0] pl_raddr;
    logic [31:0] tb_mstatus;
    logic [31:0] tb_mepc;
    logic [31:0] csr_rdata;
    logic        exc_ack;
    logic        mret_ack;
    logic        csr_w;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_wsc_mode;
    logic [11:0] csr_raddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  dbg_state;

    logic [31:0] tb_mtvec;
    logic [31:0] cyc = 32'h0;

    int checks = 0;
    int errors = 0;

    // {cycle[17:0], addr[11:0], data[31:0], mode[1:0]}
    logic [63:0] exp_q[$];
    // {cycle[15:0], pc[31:0]}
    logic [47:0] redir_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // CSR file model: only mtvec is ever read by the sequencer
    assign csr_rdata = (csr_raddr == 12'h305) ? tb_mtvec : 32'hDEAD_BEEF;

    csr_trap_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .exc_req      (exc_req),
        .exc_cause    (exc_cause),
        .exc_pc       (exc_pc),
        .exc_tval     (exc_tval),
        .mret_req     (mret_req),
        .pl_csr_w     (pl_csr_w),
        .pl_waddr     (pl_waddr),
        .pl_wdata     (pl_wdata),
        .pl_mode      (pl_mode),
        .pl_raddr     (pl_raddr),
        .mstatus      (tb_mstatus),
        .mepc         (tb_mepc),
        .csr_rdata    (csr_rdata),
        .exc_ack      (exc_ack),
        .mret_ack     (mret_ack),
        .csr_w        (csr_w),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .csr_wsc_mode (csr_wsc_mode),
        .csr_raddr    (csr_raddr),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dbg_state    (dbg_state)
    );

    function automatic logic [31:0] model_trap_ms(input logic [31:0] ms);
        return (ms & 32'hFFFF_E777) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] model_mret_ms(input logic [31:0] ms);
        return (ms & 32'hFFFF_E777) | 32'h0000_1880 | (ms[7] ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] tv, input logic [31:0] cause);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
        if (tv[1:0] == 2'b01 && cause[31] == 1'b1) return base + (cause << 2);
`else
        if (cause == 32'h0 && tv == 32'h1) return base;
`endif
        return base;
    endfunction

    task automatic push_wr(input logic [31:0] c, input logic [11:0] a, input logic [31:0] d, input logic [1:0] m);
        exp_q.push_back({c[17:0], a, d, m});
    endtask

    task automatic push_redir(input logic [31:0] c, input logic [31:0] pc);
        redir_q.push_back({c[15:0], pc});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample at the falling edge, match writes/redirects to tagged expectations
    task automatic sb_sample();
        logic [63:0] got;
        logic [63:0] e;
        logic [47:0] rg;
        logic [47:0] re;
        @(negedge clk);
        if (csr_w === 1'b1) begin
            checks++;
            got = {cyc[17:0], csr_waddr, csr_wdata, csr_wsc_mode};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h mode=%b required no write",
                         cyc, csr_waddr, csr_wdata, csr_wsc_mode);
            end else begin
                e = exp_q.pop_front();
                if (got !== e)
                    begin
                        errors++;
                        $display("FAIL csr_write got cyc=%0d addr=%h data=%h mode=%b required cyc=%0d addr=%h data=%h mode=%b",
                                 cyc, csr_waddr, csr_wdata, csr_wsc_mode, e[63:46], e[45:34], e[33:2], e[1:0]);
                    end
            end
        end
        while (exp_q.size() > 0 && exp_q[0][63:46] < cyc[17:0]) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missing_write at cyc=%0d got none required addr=%h data=%h", e[63:46], e[45:34], e[33:2]);
        end
        if (redirect === 1'b1) begin
            checks++;
            rg = {cyc[15:0], redirect_pc};
            if (redir_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_redirect cyc=%0d got pc=%h required no redirect", cyc, redirect_pc);
            end else begin
                re = redir_q.pop_front();
                if (rg !== re) begin
                    errors++;
                    $display("FAIL redirect got cyc=%0d pc=%h required cyc=%0d pc=%h",
                             cyc, redirect_pc, re[47:32], re[31:0]);
                end
            end
        end
        while (redir_q.size() > 0 && redir_q[0][47:32] < cyc[15:0]) begin
            checks++;
            errors++;
            re = redir_q.pop_front();
            $display("FAIL missing_redirect at cyc=%0d got none required pc=%h", re[47:32], re[31:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exc_req = 1'b1; mret_req = 1'b1; pl_csr_w = 1'b1;
        pl_waddr = 12'h305; pl_wdata = 32'h40; pl_mode = 2'b10; pl_raddr = 12'h342;
        sb_sample();
        checks++;
        if ({exc_ack, mret_ack, redirect, stall, csr_w} !== 5'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b mack=%b redir=%b stall=%b w=%b pc=%h required all 0",
                     exc_ack, mret_ack, redirect, stall, csr_w, redirect_pc);
        end
        next_cycle();
        exc_req = 1'b0; mret_req = 1'b0; pl_csr_w = 1'b0;
        rst = 1'b0;
        sb_sample();
        checks++;
        if (dbg_state !== 3'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got state=%0d stall=%b required state=0 stall=0", dbg_state, stall);
        end
        next_cycle();
    endtask

    task automatic test_passthrough(input int n);
        logic [11:0] a;
        logic [11:0] ra;
        logic [31:0] d;
        logic [1:0]  m;
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                a = 12'h305; d = 32'h40; m = 2'b10; ra = 12'h300;
            end else begin
                a = 12'($urandom_range(0, 4095)); d = $urandom; m = 2'($urandom_range(1, 3));
                ra = 12'($urandom_range(0, 4095));
            end
            pl_csr_w = 1'b1; pl_waddr = a; pl_wdata = d; pl_mode = m; pl_raddr = ra;
            push_wr(cyc, a, d, m);
            sb_sample();
            checks++;
            if (stall !== 1'b0 || csr_raddr !== ra) begin
                errors++;
                $display("FAIL passthrough_read got stall=%b raddr=%h required stall=0 raddr=%h", stall, csr_raddr, ra);
            end
            next_cycle();
        end
        pl_csr_w = 1'b0;
    endtask

    task automatic test_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                             input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] exp_pc);
        logic [31:0] t;
        t = cyc;
        tb_mstatus = ms; tb_mtvec = tv;
        exc_pc = pc; exc_cause = cause; exc_tval = tval; exc_req = 1'b1;
        push_wr(t + 1, 12'h341, pc & 32'hFFFF_FFFC, 2'b01);
        push_wr(t + 2, 12'h342, cause, 2'b01);
        push_wr(t + 3, 12'h343, tval, 2'b01);
        push_wr(t + 4, 12'h300, model_trap_ms(ms), 2'b01);
        push_redir(t + 5, exp_pc);
        sb_sample();
        checks++;
        if (exc_ack !== 1'b1 || mret_ack !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL trap_accept got ack=%b mack=%b stall=%b required 1 0 1", exc_ack, mret_ack, stall);
        end
        next_cycle();
        exc_req = 1'b0;
        // Inputs change after accept: the DUT must use its latched copies
        exc_pc = ~pc; exc_cause = ~cause; exc_tval = ~tval; tb_mstatus = ~ms;
        for (int k = 1; k <= 5; k++) begin
            sb_sample();
            checks++;
            if (stall !== 1'b1 || exc_ack !== 1'b0 || (k < 5 && csr_raddr !== 12'h305) || redirect !== (k == 5)) begin
                errors++;
                $display("FAIL trap_seq step=%0d got stall=%b ack=%b raddr=%h redir=%b required 1 0 305 %b",
                         k, stall, exc_ack, csr_raddr, redirect, (k == 5));
            end
            next_cycle();
        end
        sb_sample();
        checks++;
        if (stall !== 1'b0 || dbg_state !== 3'd0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL trap_return got stall=%b state=%0d redir=%b required 0 0 0", stall, dbg_state, redirect);
        end
        next_cycle();
    endtask

    task automatic test_mret(input logic [31:0] ms, input logic [31:0] epc);
        logic [31:0] t;
        t = cyc;
        tb_mstatus = ms; tb_mepc = epc; mret_req = 1'b1;
        push_wr(t + 1, 12'h300, model_mret_ms(ms), 2'b01);
        push_redir(t + 2, epc);
        sb_sample();
        checks++;
        if (mret_ack !== 1'b1 || exc_ack !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL mret_accept got mack=%b ack=%b stall=%b required 1 0 1", mret_ack, exc_ack, stall);
        end
        next_cycle();
        mret_req = 1'b0; tb_mstatus = ~ms; tb_mepc = ~epc;
        for (int k = 1; k <= 3; k++) begin
            sb_sample();
            checks++;
            if (stall !== (k < 3) || mret_ack !== 1'b0) begin
                errors++;
                $display("FAIL mret_seq step=%0d got stall=%b mack=%b required %b 0", k, stall, mret_ack, (k < 3));
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        logic [31:0] t;
        logic [31:0] ms;
        t = cyc; ms = 32'h0000_0088;
        tb_mstatus = ms; tb_mtvec = 32'h0000_0400; tb_mepc = 32'h0000_0500;
        exc_pc = 32'h0000_0222; exc_cause = 32'h5; exc_tval = 32'h77; exc_req = 1'b1;
        mret_req = 1'b1;
        pl_csr_w = 1'b1; pl_waddr = 12'h341; pl_wdata = 32'hFFFF; pl_mode = 2'b01; pl_raddr = 12'h0;
        push_wr(t + 1, 12'h341, 32'h0000_0220, 2'b01);
        push_wr(t + 2, 12'h342, 32'h5, 2'b01);
        push_wr(t + 3, 12'h343, 32'h77, 2'b01);
        push_wr(t + 4, 12'h300, model_trap_ms(ms), 2'b01);
        push_redir(t + 5, 32'h0000_0400);
        push_wr(t + 7, 12'h300, model_mret_ms(ms), 2'b01);
        push_redir(t + 8, 32'h0000_0500);
        sb_sample();
        checks++;
        if (exc_ack !== 1'b1 || mret_ack !== 1'b0 || csr_w !== 1'b0) begin
            errors++;
            $display("FAIL prio_accept got ack=%b mack=%b w=%b required 1 0 0", exc_ack, mret_ack, csr_w);
        end
        next_cycle();
        exc_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            sb_sample();
            checks++;
            if (mret_ack !== (k == 6) || stall !== 1'b1) begin
                errors++;
                $display("FAIL prio_mret_wait step=%0d got mack=%b stall=%b required %b 1", k, mret_ack, stall, (k == 6));
            end
            next_cycle();
        end
        mret_req = 1'b0; pl_csr_w = 1'b0;
        for (int k = 7; k <= 9; k++) begin
            sb_sample();
            checks++;
            if (stall !== (k < 9)) begin
                errors++;
                $display("FAIL prio_mret_seq step=%0d got stall=%b required %b", k, stall, (k < 9));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] t;
        t = cyc;
        tb_mstatus = 32'h8; tb_mtvec = 32'h600;
        exc_pc = 32'h0000_0300; exc_cause = 32'h3; exc_tval = 32'h9; exc_req = 1'b1;
        push_wr(t + 1, 12'h341, 32'h0000_0300, 2'b01);
        sb_sample();
        next_cycle();
        exc_req = 1'b0;
        sb_sample();
        next_cycle();
        rst = 1'b1;
        sb_sample();
        checks++;
        if ({exc_ack, mret_ack, redirect, stall, csr_w} !== 5'b0 || redirect_pc !== 32'h0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL midflight_reset got ack=%b mack=%b redir=%b stall=%b w=%b pc=%h state=%0d required all 0",
                     exc_ack, mret_ack, redirect, stall, csr_w, redirect_pc, dbg_state);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sb_sample();
            checks++;
            if (stall !== 1'b0 || redirect !== 1'b0 || dbg_state !== 3'd0) begin
                errors++;
                $display("FAIL midflight_after step=%0d got stall=%b redir=%b state=%0d required 0 0 0",
                         k, stall, redirect, dbg_state);
            end
            next_cycle();
        end
    endtask

    initial begin
        logic [31:0] r_pc;
        logic [31:0] r_cause;
        logic [31:0] r_ms;
        logic [31:0] r_tv;
        rst = 1'b1;
        exc_req = 1'b0; exc_cause = 32'h0; exc_pc = 32'h0; exc_tval = 32'h0;
        mret_req = 1'b0; pl_csr_w = 1'b0; pl_waddr = 12'h0; pl_wdata = 32'h0;
        pl_mode = 2'b00; pl_raddr = 12'h0; tb_mstatus = 32'h0; tb_mepc = 32'h0; tb_mtvec = 32'h0;
        next_cycle();

        test_reset();
        test_passthrough(6);
        test_trap(32'h100, 32'h2, 32'h13, 32'h88, 32'h200, 32'h200);
        test_mret(32'h1880, 32'h104);
`ifdef CSR_TRAP_VECTORED_EN
        test_trap(32'h104, 32'h8000_0007, 32'h0, 32'h8, 32'h201, 32'h21C);
`else
        test_trap(32'h104, 32'h8000_0007, 32'h0, 32'h8, 32'h201, 32'h200);
`endif
        test_priority();
        test_reset_midflight();
        for (int i = 0; i < 4; i++) begin
            r_pc = $urandom; r_cause = $urandom; r_ms = $urandom; r_tv = $urandom;
            if (i == 0) r_tv[1:0] = 2'b01;
            if (i == 0) r_cause[31] = 1'b1;
            test_trap(r_pc, r_cause, $urandom, r_ms, r_tv, model_target(r_tv, r_cause));
            test_mret($urandom, $urandom);
        end
        test_passthrough(3);

        for (int k = 0; k < 3; k++) begin
            sb_sample();
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0 || redir_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations got writes=%0d redirects=%0d required 0 0", exp_q.size(), redir_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
